// File: rtl/tristate_rx.sv
// tristate_rx: receiving end of a WIDTH-bit shared tristate data bus.
//
// Captures a word while the remote driver holds bus_en high, acknowledges it
// with a four-phase handshake (IDLE -> ACK -> TURN), and buffers the words
// in a DEPTH-entry FIFO for the local consumer. Acknowledge is withheld
// while the FIFO is full, which stalls the driver.
//
// Optional feature: define TRISTATE_RX_SYNC_EN to pass bus_en through a
// 2-flop synchronizer before it is used (adds 2 cycles of latency).
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   bus_d    in   bus data, valid while bus_en = 1
//   bus_en   in   remote driver enable
//   bus_ack  out  registered acknowledge to the driver
//   rd_en    in   pop request from the local consumer
//   rd_data  out  FIFO head word (show-ahead), 0 when empty
//   empty    out  FIFO holds no words
//   full     out  FIFO holds DEPTH words
//   count    out  FIFO occupancy
module tristate_rx #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           bus_d,
  input  logic                       bus_en,
  output logic                       bus_ack,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StAck, StTurn} state_e;

  state_e              state_q, state_d;
  logic                ack_q, ack_d;
  logic                en_s;
  logic                push, pop;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];

  // Enable conditioning
`ifdef TRISTATE_RX_SYNC_EN
  logic en_meta_q, en_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_meta_q <= 1'b0;
      en_sync_q <= 1'b0;
    end else begin
      en_meta_q <= bus_en;
      en_sync_q <= en_meta_q;
    end
  end

  assign en_s = en_sync_q;
`else
  assign en_s = bus_en;
`endif

  // FIFO status comes from the registered count only, so a pop cannot
  // make room for a push in the same cycle.
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign pop = rd_en && !empty;

  // Handshake FSM
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en_s && !full) begin
          push    = 1'b1;
          state_d = StAck;
        end
      end
      StAck: begin
        if (!en_s) state_d = StTurn;
      end
      StTurn: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Acknowledge is registered: it tracks the state being entered.
    ack_d = (state_d == StAck);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  assign bus_ack = ack_q;

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus_d;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_tristate_rx.sv
// Directed self-checking bench for tristate_rx (WIDTH = 4, DEPTH = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tristate_rx;

`ifdef TRISTATE_RX_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] bus_d;
  logic       bus_en;
  logic       bus_ack;
  logic       rd_en;
  logic [3:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  tristate_rx #(
    .WIDTH (4),
    .DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus_d   (bus_d),
    .bus_en  (bus_en),
    .bus_ack (bus_ack),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for bus_ack to reach val; a timeout shows up as a failed check.
  task automatic wait_ack(input logic val, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_ack !== val && n < 16);
    check(tag, {31'b0, bus_ack}, {31'b0, val});
  endtask

  // Full four-phase handshake; returns on the negedge after TURN is entered.
  task automatic hs(input logic [3:0] word);
    bus_d  = word;
    bus_en = 1'b1;
    wait_ack(1'b1, "hs_ack_rise");
    bus_en = 1'b0;
    wait_ack(1'b0, "hs_ack_fall");
    @(negedge clk);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    rst    = 1'b0;
    bus_d  = 4'h0;
    bus_en = 1'b0;
    rd_en  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ack",   {31'b0, bus_ack}, 32'd0);
    check("rst_empty", {31'b0, empty},   32'd1);
    check("rst_full",  {31'b0, full},    32'd0);
    check("rst_count", {29'b0, count},   32'd0);
    check("rst_data",  {28'b0, rd_data}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single word with exact timing
    bus_d  = 4'b1010;
    bus_en = 1'b1;
    for (int i = 0; i < SL; i++) begin
      @(negedge clk);
      check("sw_sync_no_ack", {31'b0, bus_ack}, 32'd0);
      check("sw_sync_no_push", {29'b0, count}, 32'd0);
    end
    @(negedge clk);
    check("sw_ack_rise", {31'b0, bus_ack}, 32'd1);
    check("sw_count",    {29'b0, count},   32'd1);
    check("sw_data",     {28'b0, rd_data}, 32'hA);
    check("sw_empty",    {31'b0, empty},   32'd0);
    bus_d  = 4'h0;
    bus_en = 1'b0;
    for (int i = 0; i < SL; i++) begin
      @(negedge clk);
      check("sw_sync_ack_hold", {31'b0, bus_ack}, 32'd1);
    end
    @(negedge clk);
    check("sw_ack_fall", {31'b0, bus_ack}, 32'd0);
    check("sw_count2",   {29'b0, count},   32'd1);
    check("sw_data2",    {28'b0, rd_data}, 32'hA);
    @(negedge clk);
    pop_one();
    check("sw_pop_empty", {31'b0, empty},   32'd1);
    check("sw_pop_data",  {28'b0, rd_data}, 32'd0);

    // Fill to DEPTH, then stall a fifth word
    hs(4'h1);
    hs(4'h2);
    hs(4'h3);
    hs(4'h4);
    check("fill_full",  {31'b0, full},    32'd1);
    check("fill_count", {29'b0, count},   32'd4);
    check("fill_head",  {28'b0, rd_data}, 32'h1);
    bus_d  = 4'h5;
    bus_en = 1'b1;
    for (int i = 0; i < 4 + SL; i++) begin
      @(negedge clk);
      check("stall_ack",   {31'b0, bus_ack}, 32'd0);
      check("stall_count", {29'b0, count},   32'd4);
    end
    pop_one();
    // Pop edge: full was still set, so no push yet
    check("stall_pop_count", {29'b0, count},   32'd3);
    check("stall_pop_head",  {28'b0, rd_data}, 32'h2);
    check("stall_pop_ack",   {31'b0, bus_ack}, 32'd0);
    @(negedge clk);
    check("late_push_ack",   {31'b0, bus_ack}, 32'd1);
    check("late_push_count", {29'b0, count},   32'd4);
    bus_en = 1'b0;
    wait_ack(1'b0, "late_ack_fall");
    @(negedge clk);
    check("drain_h2", {28'b0, rd_data}, 32'h2);
    pop_one();
    check("drain_h3", {28'b0, rd_data}, 32'h3);
    pop_one();
    check("drain_h4", {28'b0, rd_data}, 32'h4);
    pop_one();
    check("drain_h5", {28'b0, rd_data}, 32'h5);
    pop_one();
    check("drain_empty", {31'b0, empty}, 32'd1);

    // Simultaneous push and pop at count = 2, across the pointer wrap
    hs(4'h6);
    hs(4'h7);
    check("pp_count0", {29'b0, count}, 32'd2);
    bus_d  = 4'h8;
    bus_en = 1'b1;
    repeat (SL) @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("pp1_count", {29'b0, count},   32'd2);
    check("pp1_head",  {28'b0, rd_data}, 32'h7);
    check("pp1_ack",   {31'b0, bus_ack}, 32'd1);
    bus_en = 1'b0;
    wait_ack(1'b0, "pp1_ack_fall");
    @(negedge clk);
    bus_d  = 4'h9;
    bus_en = 1'b1;
    repeat (SL) @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("pp2_count", {29'b0, count},   32'd2);
    check("pp2_head",  {28'b0, rd_data}, 32'h8);
    bus_en = 1'b0;
    wait_ack(1'b0, "pp2_ack_fall");
    @(negedge clk);
    pop_one();
    check("pp_wrap_head", {28'b0, rd_data}, 32'h9);
    pop_one();
    check("pp_empty", {31'b0, empty}, 32'd1);

    // rd_en held while empty
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ue_count", {29'b0, count},   32'd0);
      check("ue_data",  {28'b0, rd_data}, 32'd0);
      check("ue_empty", {31'b0, empty},   32'd1);
    end
    rd_en = 1'b0;
    hs(4'hB);
    check("ue_ptr_head", {28'b0, rd_data}, 32'hB);
    check("ue_ptr_count", {29'b0, count},  32'd1);
    pop_one();

    // Reset asserted during ACK with count = 3
    hs(4'h1);
    hs(4'h2);
    bus_d  = 4'h3;
    bus_en = 1'b1;
    wait_ack(1'b1, "rst_mid_ack");
    check("rst_mid_count_pre", {29'b0, count}, 32'd3);
    rst = 1'b0;
    #1;
    check("rst_mid_ack_low", {31'b0, bus_ack}, 32'd0);
    check("rst_mid_count",   {29'b0, count},   32'd0);
    check("rst_mid_empty",   {31'b0, empty},   32'd1);
    check("rst_mid_data",    {28'b0, rd_data}, 32'd0);
    bus_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    hs(4'hC);
    check("post_rst_head",  {28'b0, rd_data}, 32'hC);
    check("post_rst_count", {29'b0, count},   32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tristate_rx.md
# tristate_rx

Receiving end of the 4-bit shared tristate data bus: captures words a remote tristate driver places on the bus while its enable is high, acknowledges each word with a four-phase handshake, and buffers the words in a small FIFO for the local consumer. Sits between the bus pins and local logic. Applies backpressure to the driver by withholding acknowledge when the FIFO is full.

## Interface
- WIDTH, 4, bus and data word width in bits
- DEPTH, 4, FIFO depth in words; power of two, ≥ 2

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- bus_d  in  WIDTH  shared bus data, valid while bus_en = 1
- bus_en  in  1  remote driver enable; 1 = driver is presenting a word
- bus_ack  out  1  registered acknowledge to the driver
- rd_en  in  1  pop request from the local consumer
- rd_data  out  WIDTH  FIFO head word, show-ahead
- empty  out  1  FIFO holds no words
- full  out  1  FIFO holds DEPTH words
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- FSM states: IDLE, ACK, TURN. Reset state IDLE.
- IDLE: if en_s = 1 and full = 0, push bus_d into the FIFO and go to ACK. If en_s = 1 and full = 1, stay in IDLE with no push (stall).
- ACK: bus_ack = 1. Stay until en_s = 0, then go to TURN. bus_d is ignored in ACK, and no second push occurs.
- TURN: bus_ack = 0 for one cycle of bus turnaround, then go to IDLE unconditionally. en_s is ignored in TURN.
- en_s is bus_en, or bus_en after the synchronizer (see Configuration).
- FIFO: circular buffer with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. count is tracked separately.
- Pop: when rd_en = 1 and empty = 0, advance the read pointer. When empty = 1, rd_en is ignored.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- full is evaluated from the registered count at the start of the cycle. A pop in the same cycle does not enable a push in that cycle; the push occurs in the next IDLE cycle.
- rd_data equals the word at the read pointer. It is 0 when empty = 1.

## Timing
- Reset values: bus_ack = 0, empty = 1, full = 0, count = 0, rd_data = 0, both pointers 0, FSM IDLE.
- Assertion of rst mid-handshake returns the FSM to IDLE, flushes the FIFO, and drops bus_ack immediately. Buffered data is lost.
- Push occurs on the same edge that samples en_s = 1 in IDLE. bus_ack rises in the following cycle.
- Push-to-visibility latency: the word appears on rd_data, and empty falls, one cycle after the push edge.
- bus_ack falls one cycle after en_s = 0 is sampled in ACK.
- Minimum handshake period is 3 cycles: one IDLE cycle, one ACK cycle, one TURN cycle.
- The driver must hold bus_d stable from bus_en rise until bus_ack rises. This is a protocol requirement on the driver and is not checked by this block.

## Configuration
- TRISTATE_RX_SYNC_EN defined:
  - bus_en passes through a 2-flop synchronizer (reset to 0) to form en_s.
  - The synchronizer adds 2 cycles to the delay from bus_en rise to push, and from bus_en fall to bus_ack fall.
  - bus_d is not synchronized; the driver's hold requirement covers it.
- Not defined: en_s = bus_en directly, with the latencies listed under Timing.

## Test plan
- Single word: bus_d = 4'b1010 with bus_en = 1 from IDLE -> push, bus_ack = 1 the next cycle. Drop bus_en -> bus_ack = 0 one cycle later. rd_data = 4'b1010, count = 1.
- Fill: 4 handshakes with 0x1, 0x2, 0x3, 0x4 -> full = 1, count = 4. A fifth word 0x5 with bus_en held high -> bus_ack stays 0 and no push. Pulse rd_en once -> rd_data = 0x2, and 0x5 is pushed on a later IDLE cycle.
- Simultaneous push and pop with count = 2 -> count stays 2, pointers advance, and the read order is preserved across the pointer wrap at DEPTH.
- rd_en held high while empty = 1 -> count stays 0, rd_data = 0, no pointer movement.
- rst asserted during ACK with count = 3 -> bus_ack = 0, count = 0, empty = 1 immediately.
- With TRISTATE_RX_SYNC_EN defined: bus_en rise -> push exactly 2 cycles later than without the macro; bus_ack timing shifts by the same amount.
